// File: rtl/balanced_out_collector.sv
// Back end for a path-balanced combinational netlist: tracks in-flight launches, captures
// net_out exactly DEPTH cycles after each launch, and queues results behind valid/ready.
module balanced_out_collector #(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] net_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    credit_cnt,
    output logic             err_ovf
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DEPTH-1:0] pipe;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             launch;
    logic             pop;
    logic             capture;
    logic             full;
    logic             do_push;

    // A credit stands for one FIFO slot reserved by a launch still in the pipe or queued.
    assign in_ready  = (credit_cnt != '0);
    assign launch    = in_valid & in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign capture   = pipe[DEPTH-1];
    assign full      = (count == CW'(FIFO_DEPTH));
    assign do_push   = capture & (~full | pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe       <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            credit_cnt <= CW'(FIFO_DEPTH);
            err_ovf    <= 1'b0;
        end else begin
            pipe[0] <= launch;
            for (int k = 1; k < DEPTH; k++) begin
                pipe[k] <= pipe[k-1];
            end

            if (launch && !pop) begin
                credit_cnt <= credit_cnt - CW'(1);
            end else if (pop && !launch) begin
                credit_cnt <= credit_cnt + CW'(1);
            end

            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end

            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (capture && full && !pop) begin
                err_ovf <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; out_data is masked by out_valid so stale contents never leak.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= net_out;
        end
    end

endmodule

// File: tb/tb_balanced_out_collector.sv
// Randomized self-checking bench: a queue-based model of launches in flight and queued results.
module tb_balanced_out_collector;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int FD    = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] net_out = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    credit_cnt;
    logic             err_ovf;

    always #5 clk = ~clk;

    balanced_out_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFO_DEPTH(FD), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .net_out(net_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .credit_cnt(credit_cnt), .err_ovf(err_ovf)
    );

    typedef struct {
        int         t;
        logic [1:0] d;
    } flight_t;

    flight_t    inflight[$];
    logic [1:0] fifo_q[$];
    bit         m_err;
    int         cyc;
    int         n_tests;
    int         n_fail;
    int         n_launch;
    int         n_pop;

    function automatic int m_credit();
        return FD - fifo_q.size() - inflight.size();
    endfunction

    function automatic logic [8:0] expv();
        logic       v;
        logic [1:0] d;
        logic       r;
        v = (fifo_q.size() != 0);
        d = v ? fifo_q[0] : 2'b00;
        r = (m_credit() != 0);
        return {v, d, r, CW'(m_credit()), m_err};
    endfunction

    function automatic logic [8:0] obsv();
        return {out_valid, out_data, in_ready, credit_cnt, err_ovf};
    endfunction

    always @(negedge clk) begin
        if (rst_n) assert (credit_cnt <= CW'(FD));
    end

    // Drive one cycle from a negedge, advance the model, and return at the next negedge.
    task automatic cycle(input bit iv, input bit ordy, input logic [1:0] ld);
        logic [1:0] nd;
        bit         launch;
        bit         pop;
        bit         cap;
        flight_t    f;
        nd  = 2'($urandom);
        cap = (inflight.size() > 0) && (inflight[0].t == cyc - DEPTH);
        if (cap) nd = inflight[0].d;
        in_valid  = iv;
        out_ready = ordy;
        net_out   = nd;
        launch = iv && (m_credit() != 0);
        pop    = ordy && (fifo_q.size() != 0);
        if (pop) begin
            void'(fifo_q.pop_front());
            n_pop++;
        end
        if (cap) begin
            f = inflight.pop_front();
            if (fifo_q.size() < FD) fifo_q.push_back(f.d);
            else m_err = 1'b1;
        end
        if (launch) begin
            inflight.push_back('{cyc, ld});
            n_launch++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (obsv() !== {1'b0, 2'b00, 1'b1, CW'(FD), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=%b", obsv(), {1'b0, 2'b00, 1'b1, CW'(FD), 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        cycle(1'b1, 1'b0, 2'b10);
        for (int k = 1; k <= 5; k++) begin
            n_tests++;
            if (out_valid !== (k == 5) || obsv() !== expv()) begin
                n_fail++;
                $display("FAIL single_latency k=%0d got=%b want=%b", k, obsv(), expv());
            end
            if (k < 5) cycle(1'b0, 1'b0, 2'b00);
        end
        n_tests++;
        if (out_data !== 2'b10) begin
            n_fail++;
            $display("FAIL single_data got=%b want=10", out_data);
        end
        cycle(1'b0, 1'b1, 2'b00);
        n_tests++;
        if (credit_cnt !== CW'(FD) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_credit got=%0d valid=%b want=8 valid=0", credit_cnt, out_valid);
        end
    endtask

    task automatic test_fill();
        int l0;
        l0 = n_launch;
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (in_ready !== (i < FD) || obsv() !== expv()) begin
                n_fail++;
                $display("FAIL fill_ready i=%0d got=%b want=%b", i, obsv(), expv());
            end
            cycle(1'b1, 1'b0, 2'(i));
        end
        n_tests++;
        if (n_launch - l0 != FD || fifo_q.size() != FD) begin
            n_fail++;
            $display("FAIL fill_count got=%0d want=%0d", n_launch - l0, FD);
        end
        for (int i = 0; i < FD + 1; i++) begin
            n_tests++;
            if (obsv() !== expv()) begin
                n_fail++;
                $display("FAIL fill_drain i=%0d got=%b want=%b", i, obsv(), expv());
            end
            cycle(1'b0, 1'b1, 2'b00);
        end
        n_tests++;
        if (err_ovf !== 1'b0 || out_valid !== 1'b0 || credit_cnt !== CW'(FD)) begin
            n_fail++;
            $display("FAIL fill_end got err=%b valid=%b credit=%0d want 0 0 8", err_ovf, out_valid, credit_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = n_pop;
        for (int i = 0; i < 20 + DEPTH + 2; i++) begin
            n_tests++;
            if ((i < 20 && in_ready !== 1'b1) || (i >= DEPTH + 1 && i < DEPTH + 21 && out_valid !== 1'b1)
                || obsv() !== expv()) begin
                n_fail++;
                $display("FAIL b2b i=%0d got=%b want=%b", i, obsv(), expv());
            end
            cycle(i < 20, 1'b1, 2'($urandom));
        end
        n_tests++;
        if (n_pop - p0 != 20) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d want=20", n_pop - p0);
        end
    endtask

    task automatic test_full_flow();
        for (int i = 0; i < FD + DEPTH + 1; i++) cycle(i < FD, 1'b0, 2'($urandom));
        n_tests++;
        if (credit_cnt !== '0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_state got credit=%0d ready=%b valid=%b want 0 0 1", credit_cnt, in_ready, out_valid);
        end
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (obsv() !== expv()) begin
                n_fail++;
                $display("FAIL full_flow i=%0d got=%b want=%b", i, obsv(), expv());
            end
            cycle(i < 16, 1'b1, 2'($urandom));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            n_tests++;
            if (obsv() !== expv()) begin
                n_fail++;
                $display("FAIL random i=%0d got=%b want=%b", i, obsv(), expv());
            end
            if (i < 380) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 2'($urandom));
            else cycle(1'b0, 1'b1, 2'b00);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 2'b11);
        cycle(1'b1, 1'b0, 2'b01);
        repeat (4) cycle(1'b0, 1'b0, 2'b00);
        repeat (3) cycle(1'b1, 1'b0, 2'b10);
        n_tests++;
        if (credit_cnt !== CW'(3) || obsv() !== expv()) begin
            n_fail++;
            $display("FAIL rstmid_pre got=%b want=%b", obsv(), expv());
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obsv() !== {1'b0, 2'b00, 1'b1, CW'(FD), 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_async got=%b want=%b", obsv(), {1'b0, 2'b00, 1'b1, CW'(FD), 1'b0});
        end
        inflight.delete();
        fifo_q.delete();
        m_err = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (out_valid !== 1'b0 || credit_cnt !== CW'(FD) || obsv() !== expv()) begin
                n_fail++;
                $display("FAIL rstmid_stale i=%0d got=%b want=%b", i, obsv(), expv());
            end
            cycle(1'b0, 1'b1, 2'b00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        n_launch = 0;
        n_pop = 0;
        m_err = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_full_flow();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
